// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the write-back path.
package regfile_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (with wrap).
// ptr moves just past the winner whenever the caller signals advance.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  import regfile_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  w_ptr_nxt;
  logic [2*N-1:0] w_req_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_gnt;
  logic [2*N-1:0] w_gnt_dbl;
  logic [4:0]     w_gidx;

  // Rotate requests so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    w_req_dbl = {req, req} >> r_ptr;
    w_rot     = w_req_dbl[N-1:0];
    w_rot_gnt = w_rot & (-w_rot);
    w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << r_ptr;
    grant     = w_gnt_dbl[2*N-1:N];
  end

  // Next pointer is one past the granted requester, wrapping at N.
  always_comb begin
    w_gidx = onehot_to_idx(32'(grant));
    if (int'(w_gidx) >= N - 1) w_ptr_nxt = '0;
    else                       w_ptr_nxt = PW'(w_gidx + 5'd1);
  end

  // Pointer register; only moves on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ptr <= '0;
    else if (advance) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus the
// pending-write busy map read by issue/stall logic.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = REG_DW,
  parameter int AW   = REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic [NUM_REGS-1:0] busy_map,
  output logic               rf_regW,
  output logic [AW-1:0]      rf_wrA,
  output logic [DW-1:0]      rf_wrD
);

  logic [NREQ-1:0]     w_grant;
  logic                w_hs;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_regw;
  logic [AW-1:0]       r_wra;
  logic [DW-1:0]       r_wrd;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_hs),
    .grant   (w_grant)
  );

  // Grant is masked during reset so nothing looks accepted while rst_n is low.
  always_comb begin
    req_ready = w_grant & {NREQ{rst_n}};
    w_hs      = |req_ready;
  end

  // Select the winning requester's address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  // Busy map: accepted write clears, new reservation sets (set wins), r0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_hs)      w_busy_nxt[w_addr]   = 1'b0;
    if (rsv_valid) w_busy_nxt[rsv_addr] = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy map register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Write-port output stage; address/data hold when idle, r0 writes suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regw <= 1'b0;
      r_wra  <= '0;
      r_wrd  <= '0;
    end else if (w_hs) begin
      r_regw <= (w_addr != AW'(ZERO_REG));
      r_wra  <= w_addr;
      r_wrd  <= w_data;
    end else begin
      r_regw <= 1'b0;
    end
  end

  assign busy_map = r_busy;
  assign rf_regW  = r_regw;
  assign rf_wrA   = r_wra;
  assign rf_wrD   = r_wrd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed table, corner sequences, random run.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic [31:0]       busy_map;
  logic              rf_regW;
  logic [AW-1:0]     rf_wrA;
  logic [DW-1:0]     rf_wrD;

  logic [AW-1:0] t_addr [NREQ];
  logic [DW-1:0] t_data [NREQ];

  assign req_addr = {t_addr[2], t_addr[1], t_addr[0]};
  assign req_data = {t_data[2], t_data[1], t_data[0]};

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy_map  (busy_map),
    .rf_regW   (rf_regW),
    .rf_wrA    (rf_wrA),
    .rf_wrD    (rf_wrD)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_regw;
  logic [4:0]  m_wra;
  logic [31:0] m_wrd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_regw = 1'b0;
    m_wra  = '0;
    m_wrd  = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic do_cycle(output int gi, output logic [NREQ-1:0] rdy_seen);
    logic [NREQ-1:0] exp_g;
    #1;
    gi = model_grant();
    exp_g = '0;
    if (gi >= 0) exp_g[gi] = 1'b1;
    rdy_seen = req_ready;
    chk("ready", req_ready, exp_g);
    @(posedge clk);
    if (gi >= 0) begin
      m_ptr  = (gi + 1) % NREQ;
      m_regw = (t_addr[gi] != 0);
      m_wra  = t_addr[gi];
      m_wrd  = t_data[gi];
      m_busy[t_addr[gi]] = 1'b0;
    end else begin
      m_regw = 1'b0;
    end
    if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    #1;
    chk("rf_regW", rf_regW, m_regw);
    chk("busy_map", busy_map, m_busy);
    if (m_regw) begin
      chk("rf_wrA", rf_wrA, m_wra);
      chk("rf_wrD", rf_wrD, m_wrd);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic        rsv_v;
    logic [4:0]  rsv_a;
    logic [2:0]  exp_ready;
    logic        exp_regw;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int               gi;
    logic [NREQ-1:0]  rdy;
    logic [NREQ-1:0]  pending;
    int               waitc [NREQ];

    // Contention/scoreboard table from reset: a0=3, a1=4, a2=6
    vecs[0] = '{3'b111, 1'b1, 5'd3, 3'b001, 1'b1, 32'h0000_0008};
    vecs[1] = '{3'b111, 1'b1, 5'd4, 3'b010, 1'b1, 32'h0000_0018};
    vecs[2] = '{3'b111, 1'b0, 5'd0, 3'b100, 1'b1, 32'h0000_0018};
    vecs[3] = '{3'b111, 1'b1, 5'd6, 3'b001, 1'b1, 32'h0000_0050};
    vecs[4] = '{3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 32'h0000_0050};
    vecs[5] = '{3'b100, 1'b0, 5'd0, 3'b100, 1'b1, 32'h0000_0010};
    vecs[6] = '{3'b100, 1'b0, 5'd0, 3'b100, 1'b1, 32'h0000_0010};
    vecs[7] = '{3'b010, 1'b0, 5'd0, 3'b010, 1'b1, 32'h0000_0000};
    vecs[8] = '{3'b011, 1'b0, 5'd0, 3'b001, 1'b1, 32'h0000_0000};
    vecs[9] = '{3'b000, 1'b1, 5'd0, 3'b000, 1'b0, 32'h0000_0000};

    // Reset with every requester valid and a reservation pending
    req_valid = 3'b111;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    t_addr[0] = 5'd3; t_addr[1] = 5'd4; t_addr[2] = 5'd6;
    for (int i = 0; i < NREQ; i++) t_data[i] = 32'hDEAD_0000 + i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", req_ready, 3'b000);
    chk("reset_regW", rf_regW, 1'b0);
    chk("reset_busy", busy_map, 32'h0);
    chk("reset_wrA", rf_wrA, 5'd0);
    chk("reset_wrD", rf_wrD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed table
    for (int v = 0; v < 10; v++) begin
      req_valid = vecs[v].vld;
      rsv_valid = vecs[v].rsv_v;
      rsv_addr  = vecs[v].rsv_a;
      for (int i = 0; i < NREQ; i++) t_data[i] = 32'h1000 * (i + 1) + v;
      do_cycle(gi, rdy);
      chk($sformatf("vec%0d_ready", v), rdy, vecs[v].exp_ready);
      chk($sformatf("vec%0d_regW", v), rf_regW, vecs[v].exp_regw);
      chk($sformatf("vec%0d_busy", v), busy_map, vecs[v].exp_busy);
    end

    // Single write to r5 via requester 1
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 5'd5;
    do_cycle(gi, rdy);
    chk("single_busy_set", busy_map[5], 1'b1);
    req_valid = 3'b010; rsv_valid = 1'b0;
    t_addr[1] = 5'd5; t_data[1] = 32'h0000_01F4;
    do_cycle(gi, rdy);
    chk("single_ready", rdy, 3'b010);
    chk("single_regW", rf_regW, 1'b1);
    chk("single_wrA", rf_wrA, 5'd5);
    chk("single_wrD", rf_wrD, 32'd500);
    chk("single_busy_clr", busy_map[5], 1'b0);

    // Zero register: accepted but never written, never reserved
    req_valid = 3'b001; t_addr[0] = 5'd0; t_data[0] = 32'd100;
    do_cycle(gi, rdy);
    chk("zero_ready", rdy, 3'b001);
    chk("zero_regW", rf_regW, 1'b0);
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 5'd0;
    do_cycle(gi, rdy);
    chk("zero_busy", busy_map[0], 1'b0);

    // Same-cycle set and clear on r7: set wins
    rsv_addr = 5'd7;
    do_cycle(gi, rdy);
    req_valid = 3'b100; t_addr[2] = 5'd7; t_data[2] = 32'h7777;
    do_cycle(gi, rdy);
    chk("collide_ready", rdy, 3'b100);
    chk("collide_busy7", busy_map[7], 1'b1);
    chk("collide_regW", rf_regW, 1'b1);

    // Reset between handshake edge and write cycle
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 5'd9;
    do_cycle(gi, rdy);
    rsv_valid = 1'b0;
    req_valid = 3'b001; t_addr[0] = 5'd12; t_data[0] = 32'h55;
    @(posedge clk);
    #1;
    chk("midrst_pre_regW", rf_regW, 1'b1);
    chk("midrst_pre_wrA", rf_wrA, 5'd12);
    rst_n = 1'b0;
    #1;
    chk("midrst_regW", rf_regW, 1'b0);
    chk("midrst_busy", busy_map, 32'h0);
    chk("midrst_ready", req_ready, 3'b000);
    req_valid = 3'b111;
    t_addr[0] = 5'd1; t_addr[1] = 5'd2; t_addr[2] = 5'd3;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_cycle(gi, rdy);
    chk("midrst_first_grant", rdy, 3'b001);

    // Randomised run against the model; requesters hold until accepted
    pending = '0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 2) != 0) begin
          pending[i] = 1'b1;
          t_addr[i]  = 5'($urandom_range(0, 31));
          t_data[i]  = $urandom;
        end
      end
      req_valid = pending;
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 31));
      do_cycle(gi, rdy);
      for (int i = 0; i < NREQ; i++) begin
        if (pending[i] && i != gi) waitc[i]++;
      end
      if (gi >= 0) begin
        chk("rand_fair", (waitc[gi] <= NREQ - 1), 1'b1);
        waitc[gi]   = 0;
        pending[gi] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
